// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Decodes one RV32I integer/branch instruction into an ALU command and holds
// it in a single-entry valid/ready pipeline register for the execute stage.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (instr, pc, rs1_data, rs2_data)
//   flush               drops the held command and any instruction offered
//   out_valid/out_ready downstream handshake for the registered command
//   alu_a, alu_b, op, sub_enable, arith_shift, shamt   ALU controls
//   rd, rd_we           destination register and write enable
//   is_branch, br_funct3  branch flag-selection controls
//   illegal             instruction could not be decoded here
// ---------------------------------------------------------------------------
module alu_issue #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       op,
   output logic             sub_enable,
   output logic             arith_shift,
   output logic [4:0]       shamt,
   output logic [4:0]       rd,
   output logic             rd_we,
   output logic             is_branch,
   output logic [2:0]       br_funct3,
   output logic             illegal
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic             sub;
      logic             ash;
      logic [4:0]       shamt;
      logic [4:0]       rd;
      logic             rdWe;
      logic             isBranch;
      logic [2:0]       brFunct3;
      logic             illegal;
   } cmd_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   cmd_t       cmd_d, cmd_q;
   logic       valid_d, valid_q;
   logic       take;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       ill;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // The register can accept whenever it is empty or being drained this cycle.
   assign in_ready = !valid_q || out_ready;
   // Flush wins over capture so a flushed cycle never leaves a command behind.
   assign take     = in_valid && in_ready && !flush;

   // Instruction decode. Illegal encodings still produce a command, but one
   // that cannot write a register, branch or subtract.
   always_comb begin
      cmd_d    = '0;
      ill      = 1'b0;
      cmd_d.rd = instr[11:7];
      unique case (opcode)
         OPC_OP: begin
            cmd_d.a     = rs1_data;
            cmd_d.b     = rs2_data;
            cmd_d.op    = funct3;
            cmd_d.shamt = rs2_data[4:0];
            cmd_d.sub   = instr[30] && (funct3 == 3'b000);
            cmd_d.ash   = instr[30] && (funct3 == 3'b101);
            cmd_d.rdWe  = 1'b1;
            if (funct7 == 7'b0100000)
               ill = (funct3 != 3'b000) && (funct3 != 3'b101);
            else
               ill = (funct7 != 7'b0000000);
         end
         OPC_OPIMM: begin
            cmd_d.a     = rs1_data;
            cmd_d.b     = {{(WIDTH-12){instr[31]}}, instr[31:20]};
            cmd_d.op    = funct3;
            cmd_d.shamt = instr[24:20];
            cmd_d.ash   = instr[30] && (funct3 == 3'b101);
            cmd_d.rdWe  = 1'b1;
            if (funct3 == 3'b001)
               ill = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_LUI: begin
            cmd_d.b    = {instr[31:12], 12'b0};
            cmd_d.rdWe = 1'b1;
         end
         OPC_AUIPC: begin
            cmd_d.a    = pc;
            cmd_d.b    = {instr[31:12], 12'b0};
            cmd_d.rdWe = 1'b1;
         end
         OPC_BRANCH: begin
            cmd_d.a        = rs1_data;
            cmd_d.b        = rs2_data;
            cmd_d.sub      = 1'b1;
            cmd_d.isBranch = 1'b1;
            cmd_d.brFunct3 = funct3;
            ill            = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         cmd_d.rdWe     = 1'b0;
         cmd_d.isBranch = 1'b0;
         cmd_d.brFunct3 = 3'b000;
         cmd_d.sub      = 1'b0;
      end
      if (cmd_d.rd == 5'd0)
         cmd_d.rdWe = 1'b0;
      cmd_d.illegal = ill;
   end

   // Next-state for the valid bit: flush clears, capture sets, a consumed
   // command with nothing behind it clears, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      if (flush)
         valid_d = 1'b0;
      else if (take)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
   end

   // Pipeline register; the command only changes on capture, so it stays
   // stable while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         cmd_q   <= '0;
      end else begin
         valid_q <= valid_d;
         if (take)
            cmd_q <= cmd_d;
      end
   end

   assign out_valid   = valid_q;
   assign alu_a       = cmd_q.a;
   assign alu_b       = cmd_q.b;
   assign op          = cmd_q.op;
   assign sub_enable  = cmd_q.sub;
   assign arith_shift = cmd_q.ash;
   assign shamt       = cmd_q.shamt;
   assign rd          = cmd_q.rd;
   assign rd_we       = cmd_q.rdWe;
   assign is_branch   = cmd_q.isBranch;
   assign br_funct3   = cmd_q.brFunct3;
   assign illegal     = cmd_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Directed bench for alu_issue. Expected commands come from a reference
// decoder and pass through a scoreboard queue from drive time to output time.
// ---------------------------------------------------------------------------
module tb_alu_issue;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        sub;
      logic        ash;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        rdWe;
      logic        isBranch;
      logic [2:0]  brFunct3;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] instrIn = '0;
   logic [31:0] pcIn = '0;
   logic [31:0] rs1In = '0;
   logic [31:0] rs2In = '0;
   logic        flushIn = 1'b0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] aluA, aluB;
   logic [2:0]  opOut, brF3;
   logic        subEn, ashOut, rdWe, isBr, illOut;
   logic [4:0]  shamtOut, rdOut;

   int   total = 0;
   int   bad = 0;
   exp_t sbQueue[$];
   logic modelValid = 1'b0;

   alu_issue #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady),
      .instr(instrIn), .pc(pcIn), .rs1_data(rs1In), .rs2_data(rs2In),
      .flush(flushIn),
      .out_valid(outValid), .out_ready(outReady),
      .alu_a(aluA), .alu_b(aluB), .op(opOut),
      .sub_enable(subEn), .arith_shift(ashOut), .shamt(shamtOut),
      .rd(rdOut), .rd_we(rdWe), .is_branch(isBr), .br_funct3(brF3),
      .illegal(illOut)
   );

   always #5 clk = ~clk;

   // Reference RV32I decode into the expected ALU command.
   function automatic exp_t refDecode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      e  = '0;
      f3 = ins[14:12];
      f7 = ins[31:25];
      e.rd = ins[11:7];
      case (ins[6:0])
         7'h33: begin
            e.a = r1; e.b = r2; e.op = f3; e.shamt = r2[4:0]; e.rdWe = 1'b1;
            e.sub = ins[30] & (f3 == 3'd0);
            e.ash = ins[30] & (f3 == 3'd5);
            e.illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'h13: begin
            e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.op = f3;
            e.shamt = ins[24:20]; e.rdWe = 1'b1;
            e.ash = ins[30] & (f3 == 3'd5);
            e.illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         end
         7'h37: begin e.b = {ins[31:12], 12'h000}; e.rdWe = 1'b1; end
         7'h17: begin e.a = p; e.b = {ins[31:12], 12'h000}; e.rdWe = 1'b1; end
         7'h63: begin
            e.a = r1; e.b = r2; e.sub = 1'b1; e.isBranch = 1'b1; e.brFunct3 = f3;
            e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
         end
         default: e.illegal = 1'b1;
      endcase
      if (e.illegal) begin
         e.rdWe = 1'b0; e.isBranch = 1'b0; e.sub = 1'b0; e.brFunct3 = 3'd0;
      end
      if (e.rd == 5'd0) e.rdWe = 1'b0;
      return e;
   endfunction

   task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Compares the DUT command against the scoreboard head (or only the valid
   // bit when nothing is expected).
   task automatic checkOutput();
      exp_t e;
      checkField("out_valid", {31'd0, outValid}, {31'd0, modelValid});
      if (modelValid && sbQueue.size() > 0) begin
         e = sbQueue[0];
         checkField("alu_a", aluA, e.a);
         checkField("alu_b", aluB, e.b);
         checkField("op", {29'd0, opOut}, {29'd0, e.op});
         checkField("sub_enable", {31'd0, subEn}, {31'd0, e.sub});
         checkField("arith_shift", {31'd0, ashOut}, {31'd0, e.ash});
         checkField("shamt", {27'd0, shamtOut}, {27'd0, e.shamt});
         checkField("rd", {27'd0, rdOut}, {27'd0, e.rd});
         checkField("rd_we", {31'd0, rdWe}, {31'd0, e.rdWe});
         checkField("is_branch", {31'd0, isBr}, {31'd0, e.isBranch});
         checkField("br_funct3", {29'd0, brF3}, {29'd0, e.brFunct3});
         checkField("illegal", {31'd0, illOut}, {31'd0, e.illegal});
      end
   endtask

   task automatic checkReset();
      checkField("rst_out_valid", {31'd0, outValid}, 32'd0);
      checkField("rst_alu_a", aluA, 32'd0);
      checkField("rst_alu_b", aluB, 32'd0);
      checkField("rst_ctrl", {19'd0, opOut, subEn, ashOut, shamtOut, rdOut, rdWe, isBr, brF3, illOut},
                 32'd0);
   endtask

   // One cycle: drive at the falling edge, check in_ready, advance the
   // scoreboard at the rising edge, then check the registered outputs.
   task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] p,
                                input logic ordy, input logic fl);
      logic accept;
      @(negedge clk);
      inValid = iv; instrIn = ins; rs1In = r1; rs2In = r2; pcIn = p;
      outReady = ordy; flushIn = fl;
      #1;
      checkField("in_ready", {31'd0, inReady}, {31'd0, (!modelValid || ordy)});
      accept = iv && (!modelValid || ordy) && !fl;
      @(posedge clk);
      if (fl) begin
         sbQueue.delete();
         modelValid = 1'b0;
      end else begin
         if (modelValid && ordy) begin
            void'(sbQueue.pop_front());
            modelValid = 1'b0;
         end
         if (accept) begin
            sbQueue.push_back(refDecode(ins, p, r1, r2));
            modelValid = 1'b1;
         end
      end
      #1;
      checkOutput();
   endtask

   initial begin
      #3;
      checkReset();
      @(negedge clk);
      rst = 1'b0;

      // Mix of arithmetic, immediate, upper-immediate and branch forms
      applyStimulus(1, 32'h002081B3, 32'd5, 32'd7, 32'h100, 1, 0);           // ADD x3,x1,x2
      applyStimulus(1, 32'h402081B3, 32'd5, 32'd7, 32'h104, 1, 0);           // SUB
      applyStimulus(1, 32'h40335293, 32'h11, 32'h0, 32'h108, 1, 0);          // SRAI x5,x6,3
      applyStimulus(1, 32'h00208063, 32'd9, 32'd9, 32'h10C, 1, 0);           // BEQ
      applyStimulus(1, 32'hABCDE3B7, 32'h1, 32'h2, 32'h110, 1, 0);           // LUI
      applyStimulus(1, 32'h12345417, 32'h1, 32'h2, 32'h8000_0114, 1, 0);     // AUIPC
      applyStimulus(1, 32'hFFF08493, 32'h20, 32'h2, 32'h118, 1, 0);          // ADDI -1
      applyStimulus(1, 32'h40309213, 32'h3, 32'h4, 32'h11C, 1, 0);           // bad SLLI
      applyStimulus(1, 32'h4020C1B3, 32'h3, 32'h4, 32'h120, 1, 0);           // bad OP funct7
      applyStimulus(1, 32'h0000007F, 32'h3, 32'h4, 32'h124, 1, 0);           // bad opcode
      applyStimulus(1, 32'h0020C063, 32'hFFFF_FFFE, 32'h4, 32'h128, 1, 0);   // BLT
      applyStimulus(1, 32'h0020A063, 32'h1, 32'h4, 32'h12C, 1, 0);           // branch f3=010
      applyStimulus(1, 32'h00208033, 32'h1, 32'h4, 32'h130, 1, 0);           // ADD x0
      applyStimulus(1, 32'h002091B3, 32'h1, 32'h2F, 32'h134, 1, 0);          // SLL
      applyStimulus(1, 32'h4020D1B3, 32'h8000_0000, 32'h23, 32'h138, 1, 0);  // SRA
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);                    // drain

      // Backpressure: command held while a new instruction waits
      applyStimulus(1, 32'h002081B3, 32'd1, 32'd2, 32'h200, 0, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 32'h40335293, 32'd6, 32'd0, 32'h204, 0, 0);
      applyStimulus(1, 32'h40335293, 32'd6, 32'd0, 32'h204, 1, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Flush beats capture while a command is held
      applyStimulus(1, 32'h00208063, 32'd3, 32'd3, 32'h300, 0, 1);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

      // Asynchronous reset between edges drops a held command
      applyStimulus(1, 32'h002081B3, 32'd4, 32'd4, 32'h400, 0, 0);
      #1;
      rst = 1'b1;
      #1;
      checkReset();
      rst = 1'b0;
      sbQueue.delete();
      modelValid = 1'b0;
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      applyStimulus(1, 32'h12345417, 32'h0, 32'h0, 32'h500, 1, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
